stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_pkg.sv | 4 +
 rtl/rr_pick.sv | 24 ++
 rtl/stream_mux_rr.sv | 53 +++++
 tb/tb_stream_mux_rr.sv | 113 +++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types for the round-robin stream multiplexer
package stream_mux_pkg;
    typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first request at or after ptr wins
module rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    int j;
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux with external or round-robin select and registered output
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  mux_mode_t             mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_chan,
    input  logic                  out_ready
);
    logic [SEL_W-1:0] ptr, rr_idx, grant;
    logic             rr_found, grant_vld, load, xfer;
    rr_pick #(.N(N_IN)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );
    // shifting past the top bit yields zero, so sel >= N_IN never grants
    always_comb begin
        load      = !out_valid || out_ready;
        grant     = mode == MODE_RR ? rr_idx : sel;
        grant_vld = mode == MODE_RR ? rr_found : |(in_valid & (N_IN'(1) << sel));
        xfer      = load && grant_vld;
        in_ready  = (xfer && !rst) ? N_IN'(1) << grant : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= in_data[grant*WIDTH +: WIDTH];
                out_chan <= grant;
                if (mode == MODE_RR)
                    ptr <= grant == SEL_W'(N_IN - 1) ? '0 : grant + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of stream_mux_rr at N_IN=4 and N_IN=3
module tb_stream_mux_rr;
    import stream_mux_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic            rst4, out_ready4, out_valid4;
    mux_mode_t       mode4;
    logic [1:0]      sel4, out_chan4;
    logic [3:0]      in_valid4, in_ready4;
    logic [31:0]     in_data4;
    logic [7:0]      out_data4;
    logic            rst3, out_ready3, out_valid3;
    mux_mode_t       mode3;
    logic [1:0]      sel3, out_chan3;
    logic [2:0]      in_valid3, in_ready3;
    logic [23:0]     in_data3;
    logic [7:0]      out_data3;
    int pass_cnt = 0;
    int total = 0;
    stream_mux_rr #(.WIDTH(8), .N_IN(4)) dut4 (
        .clk(clk), .rst(rst4), .mode(mode4), .sel(sel4), .in_valid(in_valid4),
        .in_data(in_data4), .in_ready(in_ready4), .out_valid(out_valid4),
        .out_data(out_data4), .out_chan(out_chan4), .out_ready(out_ready4)
    );
    stream_mux_rr #(.WIDTH(8), .N_IN(3)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3), .in_valid(in_valid3),
        .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3),
        .out_data(out_data3), .out_chan(out_chan3), .out_ready(out_ready3)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [7:0] d [4] = '{8'h10, 8'h11, 8'hA5, 8'h13};
        rst4 = 1'b1; mode4 = MODE_RR; sel4 = 2'd0; in_valid4 = 4'hF; out_ready4 = 1'b1;
        in_data4 = {d[3], d[2], d[1], d[0]};
        rst3 = 1'b1; mode3 = MODE_RR; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'h32, 8'h31, 8'h30};
        step();
        step();
        check("rst_valid", 32'(out_valid4), 0);
        check("rst_data", 32'(out_data4), 0);
        check("rst_chan", 32'(out_chan4), 0);
        check("rst_ready", 32'(in_ready4), 0);
        rst4 = 1'b0;
        #1 check("first_ready", 32'(in_ready4), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_chan", 32'(out_chan4), 32'(k % 4));
            check("rr_data", 32'(out_data4), 32'(d[k % 4]));
        end
        mode4 = MODE_SEL; sel4 = 2'd2; in_valid4 = 4'b0100;
        #1 check("sel_ready", 32'(in_ready4), 32'b0100);
        step();
        check("sel_data", 32'(out_data4), 32'hA5);
        check("sel_chan", 32'(out_chan4), 2);
        check("sel_valid", 32'(out_valid4), 1);
        in_valid4 = 4'b1011;
        #1 check("sel_noready", 32'(in_ready4), 0);
        step();
        check("sel_drop", 32'(out_valid4), 0);
        check("sel_hold", 32'(out_data4), 32'hA5);
        mode4 = MODE_RR; in_valid4 = 4'b0001;
        step();
        check("skip_pre", 32'(out_chan4), 0);
        in_valid4 = 4'b1001;
        #1 check("skip_ready3", 32'(in_ready4), 32'b1000);
        step();
        check("skip_chan3", 32'(out_chan4), 3);
        #1 check("skip_wrap", 32'(in_ready4), 32'b0001);
        step();
        check("skip_chan0", 32'(out_chan4), 0);
        #1 check("skip_ptr1", 32'(in_ready4), 32'b1000);
        mode4 = MODE_SEL; sel4 = 2'd0; in_valid4 = 4'b0001; in_data4[7:0] = 8'h3C;
        step();
        check("bp_load", 32'(out_data4), 32'h3C);
        out_ready4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready", 32'(in_ready4), 0);
            step();
            check("bp_data", 32'(out_data4), 32'h3C);
            check("bp_valid", 32'(out_valid4), 1);
        end
        out_ready4 = 1'b1;
        #1 check("bp_release", 32'(in_ready4), 32'b0010);
        step();
        check("bp_next_data", 32'(out_data4), 32'h11);
        check("bp_next_chan", 32'(out_chan4), 1);
        check("bp_next_valid", 32'(out_valid4), 1);
        out_ready4 = 1'b0; rst4 = 1'b1;
        step();
        check("rst_drop", 32'(out_valid4), 0);
        rst4 = 1'b0; out_ready4 = 1'b1; mode4 = MODE_RR; in_valid4 = 4'hF;
        #1 check("rst_ptr", 32'(in_ready4), 32'b0001);
        rst3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("n3_chan", 32'(out_chan3), 32'(k % 3));
        end
        mode3 = MODE_SEL; sel3 = 2'd3;
        #1 check("n3_noready", 32'(in_ready3), 0);
        step();
        check("n3_drop", 32'(out_valid3), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
